// File: rtl/alu_rf_pipe_if.sv
// Sequencer/consumer-facing bundle for the RF + ALU execute pipe.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready handshakes.
interface alu_rf_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_rr1;
  logic [AW-1:0]     in_rr2;
  logic [AW-1:0]     in_wr;
  logic              in_we;
  logic              in_sel;
  logic [DATA_W-1:0] in_wdata;
  logic [3:0]        in_op;
  logic              in_mode;
  logic [SW-1:0]     in_shamt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_ovf;
  logic              out_illegal;
  logic              ovf_sticky;
  logic              ovf_clr;

  // Sequencer + consumer side
  modport master (
    output in_valid, in_rr1, in_rr2, in_wr, in_we, in_sel, in_wdata,
           in_op, in_mode, in_shamt, out_ready, ovf_clr,
    input  in_ready, out_valid, out_result, out_ovf, out_illegal, ovf_sticky
  );

  // Execute pipe side
  modport slave (
    input  in_valid, in_rr1, in_rr2, in_wr, in_we, in_sel, in_wdata,
           in_op, in_mode, in_shamt, out_ready, ovf_clr,
    output in_ready, out_valid, out_result, out_ovf, out_illegal, ovf_sticky
  );
endinterface

// File: rtl/alu_rf_pipe.sv
// Register file + ALU execute pipe: E holds the decoded instruction, X holds result/flags.
// Latency: accepted at edge t, result visible after edge t+1; one instruction per clock.
// Backpressure: X holds while !out_ready; in_ready drops only when E and X are both full and stalled.
module alu_rf_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 0
) (
  input logic         clk,
  input logic         rst_n,
  alu_rf_pipe_if.slave bus
);
  localparam int AW  = $clog2(NUM_REGS);
  localparam int SW  = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  typedef struct packed {
    logic [AW-1:0]     rr1;
    logic [AW-1:0]     rr2;
    logic [AW-1:0]     wr;
    logic              we;
    logic              sel;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        op;
    logic              mode;
    logic [SW-1:0]     shamt;
  } e_t;

  logic              e_vld;
  e_t                e_q;
  e_t                e_in;
  logic              x_vld;
  logic [DATA_W-1:0] x_res;
  logic              x_ovf;
  logic              x_ill;
  logic              x_we;
  logic              x_sel;
  logic [AW-1:0]     x_wr;
  logic [DATA_W-1:0] x_wdata;
  logic              ovf_st;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic              advance;
  logic              accept;
  logic              commit;
  logic              commit_wr;
  logic [DATA_W-1:0] commit_dat;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [SW-1:0]     sh;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              cmp_gt;
  logic              cmp_lt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;

  assign advance    = !x_vld | bus.out_ready;
  assign accept     = bus.in_valid & bus.in_ready;
  assign commit     = x_vld & bus.out_ready;
  // Writes to reg 0 vanish when it is hardwired to zero, so they must not forward either.
  assign commit_wr  = commit & x_we & !((ZERO_REG != 0) && (x_wr == '0));
  assign commit_dat = x_sel ? x_res : x_wdata;

  assign bus.in_ready    = advance | !e_vld;
  assign bus.out_valid   = x_vld;
  assign bus.out_result  = x_res;
  assign bus.out_ovf     = x_ovf;
  assign bus.out_illegal = x_ill;
  assign bus.ovf_sticky  = ovf_st;

  // Pack the incoming instruction for the E register
  always_comb begin
    e_in       = '0;
    e_in.rr1   = bus.in_rr1;
    e_in.rr2   = bus.in_rr2;
    e_in.wr    = bus.in_wr;
    e_in.we    = bus.in_we;
    e_in.sel   = bus.in_sel;
    e_in.wdata = bus.in_wdata;
    e_in.op    = bus.in_op;
    e_in.mode  = bus.in_mode;
    e_in.shamt = bus.in_shamt;
  end

  // Operand fetch at the E->X edge, bypassing the write X commits on that same edge
  always_comb begin
    op_a = rf[e_q.rr1];
    op_b = rf[e_q.rr2];
    if (commit_wr && x_wr == e_q.rr1) op_a = commit_dat;
    if (commit_wr && x_wr == e_q.rr2) op_b = commit_dat;
    if ((ZERO_REG != 0) && e_q.rr1 == '0) op_a = '0;
    if ((ZERO_REG != 0) && e_q.rr2 == '0) op_b = '0;
  end

  assign sh     = SW'(32'(e_q.shamt) % DATA_W);
  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign cmp_gt = e_q.mode ? ($signed(op_a) > $signed(op_b)) : (op_a > op_b);
  assign cmp_lt = e_q.mode ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

  // ALU: wrap-around arithmetic, signed overflow only for ADD/SUB, 9..15 flagged illegal
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (e_q.op)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a << sh;
      4'd5:    alu_res = op_a >> sh;
      4'd6:    alu_res = $signed(op_a) >>> sh;
      4'd7:    alu_res = {{(DATA_W-1){1'b0}}, cmp_gt};
      4'd8:    alu_res = {{(DATA_W-1){1'b0}}, cmp_lt};
      default: alu_ill = 1'b1;
    endcase
  end

  // E stage: load on accept, otherwise empty once its contents move into X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= 1'b0;
      e_q   <= '0;
    end else if (accept) begin
      e_vld <= 1'b1;
      e_q   <= e_in;
    end else if (advance) begin
      e_vld <= 1'b0;
    end
  end

  // X stage: capture ALU result on advance; an illegal op never writes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_vld   <= 1'b0;
      x_res   <= '0;
      x_ovf   <= 1'b0;
      x_ill   <= 1'b0;
      x_we    <= 1'b0;
      x_sel   <= 1'b0;
      x_wr    <= '0;
      x_wdata <= '0;
    end else if (advance) begin
      x_vld <= e_vld;
      if (e_vld) begin
        x_res   <= alu_res;
        x_ovf   <= alu_ovf;
        x_ill   <= alu_ill;
        x_we    <= e_q.we & !alu_ill;
        x_sel   <= e_q.sel;
        x_wr    <= e_q.wr;
        x_wdata <= e_q.wdata;
      end
    end
  end

  // Register file: written only when the consumer takes the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (commit_wr) begin
      rf[x_wr] <= commit_dat;
    end
  end

  // Sticky overflow over committed results; clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ovf_st <= 1'b0;
    else if (bus.ovf_clr)     ovf_st <= 1'b0;
    else if (commit && x_ovf) ovf_st <= 1'b1;
  end
endmodule

// File: tb/tb_alu_rf_pipe.sv
// Bench for alu_rf_pipe: one ordinary-r0 instance and one hardwired-zero-r0 instance.
module tb_alu_rf_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rf_pipe_if #(.DATA_W(32), .NUM_REGS(32)) b0 ();
  alu_rf_pipe_if #(.DATA_W(32), .NUM_REGS(32)) bz ();

  alu_rf_pipe #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(0)) dut  (.clk(clk), .rst_n(rst_n), .bus(b0));
  alu_rf_pipe #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dutz (.clk(clk), .rst_n(rst_n), .bus(bz));

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] er;
    logic        eo;
    logic        ei;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  int checks = 0;
  int passes = 0;
  exp_t q0[$];
  exp_t qz[$];
  logic [31:0] rf0 [32];
  logic [31:0] rfz [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  function automatic logic [31:0] rdm(input int z, input logic [4:0] r);
    if (z != 0) return (r == 5'd0) ? 32'd0 : rfz[r];
    return rf0[r];
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic mode,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e = '0;
    case (op)
      4'd0: begin e.res = a + b; e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]); end
      4'd1: begin e.res = a - b; e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a << sh;
      4'd5: e.res = a >> sh;
      4'd6: e.res = $signed(a) >>> sh;
      4'd7: e.res = {31'd0, mode ? ($signed(a) > $signed(b)) : (a > b)};
      4'd8: e.res = {31'd0, mode ? ($signed(a) < $signed(b)) : (a < b)};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive(input int z, input logic v, input logic [4:0] rr1, rr2, wr,
                       input logic we, sel, input logic [31:0] wd, input logic [3:0] op,
                       input logic mode, input logic [4:0] sh);
    if (z == 0) begin
      b0.in_valid = v; b0.in_rr1 = rr1; b0.in_rr2 = rr2; b0.in_wr = wr; b0.in_we = we;
      b0.in_sel = sel; b0.in_wdata = wd; b0.in_op = op; b0.in_mode = mode; b0.in_shamt = sh;
    end else begin
      bz.in_valid = v; bz.in_rr1 = rr1; bz.in_rr2 = rr2; bz.in_wr = wr; bz.in_we = we;
      bz.in_sel = sel; bz.in_wdata = wd; bz.in_op = op; bz.in_mode = mode; bz.in_shamt = sh;
    end
  endtask

  // Issue one instruction; the expectation (explicit or modelled) is queued once it is accepted
  task automatic send(input int z, input logic [4:0] rr1, rr2, wr, input logic we, sel,
                      input logic [31:0] wd, input logic [3:0] op, input logic mode,
                      input logic [4:0] sh, input bit use_exp, input exp_t ex);
    exp_t e;
    bit acc;
    logic [31:0] wv;
    e = use_exp ? ex : model(op, mode, rdm(z, rr1), rdm(z, rr2), sh);
    drive(z, 1'b1, rr1, rr2, wr, we, sel, wd, op, mode, sh);
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = (z == 0) ? b0.in_ready : bz.in_ready;
      @(posedge clk);
      #1;
    end
    drive(z, 1'b0, rr1, rr2, wr, we, sel, wd, op, mode, sh);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1 within 100 cycles", z);
    end else begin
      if (z == 0) q0.push_back(e); else qz.push_back(e);
      if (we && !e.ill) begin
        wv = sel ? e.res : wd;
        if (z == 0) rf0[wr] = wv;
        else if (wr != 5'd0) rfz[wr] = wv;
      end
    end
  endtask

  task automatic load(input int z, input logic [4:0] wr, input logic [31:0] v);
    send(z, 5'd0, 5'd0, wr, 1'b1, 1'b0, v, 4'd2, 1'b0, 5'd0, 1'b0, '0);
  endtask

  task automatic opx(input int z, input logic [3:0] op, input logic [4:0] rr1, rr2, wr,
                     input logic we, input logic [31:0] r, input logic o);
    exp_t e;
    e = {r, o, 1'b0};
    send(z, rr1, rr2, wr, we, 1'b1, 32'd0, op, 1'b0, 5'd0, 1'b1, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || qz.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q0.size() != 0 || qz.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0/0", q0.size(), qz.size());
    end
  endtask

  task automatic pop_chk(input int z);
    exp_t e;
    if ((z == 0 && q0.size() == 0) || (z != 0 && qz.size() == 0)) begin
      checks++;
      $display("FAIL unexpected_out dut%0d: result with empty scoreboard, required none", z);
    end else if (z == 0) begin
      e = q0.pop_front();
      chk("result", b0.out_result, e.res);
      chk("ovf", {31'd0, b0.out_ovf}, {31'd0, e.ovf});
      chk("illegal", {31'd0, b0.out_illegal}, {31'd0, e.ill});
    end else begin
      e = qz.pop_front();
      chk("z_result", bz.out_result, e.res);
      chk("z_illegal", {31'd0, bz.out_illegal}, {31'd0, e.ill});
    end
  endtask

  // Scoreboard side: every transfer is checked away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (b0.out_valid && b0.out_ready) pop_chk(0);
      if (bz.out_valid && bz.out_ready) pop_chk(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'd0, 1'b0, 32'd5,         32'd100,       5'd0,  32'd105,       1'b0, 1'b0};
    vt[1]  = '{4'd0, 1'b0, 32'h7FFFFFFF,  32'd1,         5'd0,  32'h80000000,  1'b1, 1'b0};
    vt[2]  = '{4'd1, 1'b0, 32'h80000000,  32'd1,         5'd0,  32'h7FFFFFFF,  1'b1, 1'b0};
    vt[3]  = '{4'd1, 1'b0, 32'd5,         32'd3,         5'd0,  32'd2,         1'b0, 1'b0};
    vt[4]  = '{4'd0, 1'b0, 32'hFFFFFFFF,  32'd1,         5'd0,  32'd0,         1'b0, 1'b0};
    vt[5]  = '{4'd2, 1'b0, 32'h0000F0F0,  32'h0000FF00,  5'd0,  32'h0000F000,  1'b0, 1'b0};
    vt[6]  = '{4'd3, 1'b0, 32'h0000F0F0,  32'h00000F0F,  5'd0,  32'h0000FFFF,  1'b0, 1'b0};
    vt[7]  = '{4'd4, 1'b0, 32'd1,         32'd0,         5'd31, 32'h80000000,  1'b0, 1'b0};
    vt[8]  = '{4'd5, 1'b0, 32'd6,         32'd0,         5'd1,  32'd3,         1'b0, 1'b0};
    vt[9]  = '{4'd6, 1'b0, 32'hFFFFFFFA,  32'd0,         5'd1,  32'hFFFFFFFD,  1'b0, 1'b0};
    vt[10] = '{4'd6, 1'b0, 32'h80000000,  32'd0,         5'd31, 32'hFFFFFFFF,  1'b0, 1'b0};
    vt[11] = '{4'd7, 1'b0, 32'hFFFFFFFB,  32'd6,         5'd0,  32'd1,         1'b0, 1'b0};
    vt[12] = '{4'd7, 1'b1, 32'hFFFFFFFB,  32'd6,         5'd0,  32'd0,         1'b0, 1'b0};
    vt[13] = '{4'd8, 1'b1, 32'hFFFFFFFB,  32'd6,         5'd0,  32'd1,         1'b0, 1'b0};
    vt[14] = '{4'd8, 1'b0, 32'hFFFFFFFB,  32'd6,         5'd0,  32'd0,         1'b0, 1'b0};
    vt[15] = '{4'd12, 1'b0, 32'd9,        32'd9,         5'd0,  32'd0,         1'b0, 1'b1};
    vt[16] = '{4'd1, 1'b0, 32'd3,         32'd5,         5'd0,  32'hFFFFFFFE,  1'b0, 1'b0};
    vt[17] = '{4'd5, 1'b0, 32'h80000000,  32'd0,         5'd31, 32'd1,         1'b0, 1'b0};
    vt[18] = '{4'd15, 1'b1, 32'd1,        32'd2,         5'd3,  32'd0,         1'b0, 1'b1};
    vt[19] = '{4'd4, 1'b0, 32'h00001234,  32'd0,         5'd0,  32'h00001234,  1'b0, 1'b0};
    for (int i = 0; i < 32; i++) begin rf0[i] = '0; rfz[i] = '0; end

    drive(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 5'd0);
    drive(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 5'd0);
    b0.out_ready = 1'b1; b0.ovf_clr = 1'b0;
    bz.out_ready = 1'b1; bz.ovf_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, b0.out_valid}, 32'd0);
    chk("rst_out_result", b0.out_result, 32'd0);
    chk("rst_out_ovf", {31'd0, b0.out_ovf}, 32'd0);
    chk("rst_out_illegal", {31'd0, b0.out_illegal}, 32'd0);
    chk("rst_ovf_sticky", {31'd0, b0.ovf_sticky}, 32'd0);
    chk("rst_in_ready", {31'd0, b0.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: nothing in X one edge after accept, result present after the next edge
    load(0, 5'd0, 32'd5);
    chk("lat_t1_out_valid", {31'd0, b0.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_t2_out_valid", {31'd0, b0.out_valid}, 32'd1);

    // Loads, then back-to-back dependent ADDs relying on forwarding
    load(0, 5'd1, 32'd100);
    opx(0, 4'd0, 5'd0, 5'd1, 5'd2, 1'b1, 32'd105, 1'b0);
    opx(0, 4'd0, 5'd2, 5'd2, 5'd3, 1'b1, 32'd210, 1'b0);
    drain();
    opx(0, 4'd3, 5'd2, 5'd2, 5'd9, 1'b0, 32'd105, 1'b0);
    opx(0, 4'd3, 5'd3, 5'd3, 5'd9, 1'b0, 32'd210, 1'b0);

    // Operation table; each result is read back to catch a wrong or missing write
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      e = {vt[i].er, vt[i].eo, vt[i].ei};
      load(0, 5'd10, vt[i].a);
      load(0, 5'd11, vt[i].b);
      send(0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 32'd0, vt[i].op, vt[i].mode, vt[i].sh, 1'b1, e);
      send(0, 5'd12, 5'd12, 5'd13, 1'b0, 1'b1, 32'd0, 4'd3, 1'b0, 5'd0, 1'b0, '0);
    end
    drain();

    // Sticky overflow and its clear
    chk("sticky_after_table", {31'd0, b0.ovf_sticky}, 32'd1);
    b0.ovf_clr = 1'b1;
    @(posedge clk);
    #1 b0.ovf_clr = 1'b0;
    chk("sticky_cleared", {31'd0, b0.ovf_sticky}, 32'd0);
    load(0, 5'd10, 32'h7FFFFFFF);
    load(0, 5'd11, 32'd1);
    opx(0, 4'd0, 5'd10, 5'd11, 5'd12, 1'b1, 32'h80000000, 1'b1);
    drain();
    chk("sticky_set", {31'd0, b0.ovf_sticky}, 32'd1);
    b0.ovf_clr = 1'b1;
    @(posedge clk);
    #1 b0.ovf_clr = 1'b0;
    chk("sticky_clr2", {31'd0, b0.ovf_sticky}, 32'd0);

    // Clear on the same edge as an overflowing commit wins
    b0.out_ready = 1'b0;
    opx(0, 4'd0, 5'd10, 5'd11, 5'd14, 1'b1, 32'h80000000, 1'b1);
    @(posedge clk);
    #1;
    chk("coinc_out_valid", {31'd0, b0.out_valid}, 32'd1);
    b0.ovf_clr = 1'b1;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1 b0.ovf_clr = 1'b0;
    chk("coinc_sticky", {31'd0, b0.ovf_sticky}, 32'd0);
    @(posedge clk);
    #1;
    chk("coinc_sticky_hold", {31'd0, b0.ovf_sticky}, 32'd0);

    // Back-pressure: consumer stalls 5 cycles with three instructions queued
    b0.out_ready = 1'b0;
    fork
      begin
        opx(0, 4'd2, 5'd10, 5'd11, 5'd15, 1'b1, 32'd1, 1'b0);
        opx(0, 4'd3, 5'd10, 5'd11, 5'd16, 1'b1, 32'h7FFFFFFF, 1'b0);
        opx(0, 4'd1, 5'd10, 5'd11, 5'd17, 1'b1, 32'h7FFFFFFE, 1'b0);
      end
    join_none
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_in_ready", {31'd0, b0.in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, b0.out_valid}, 32'd1);
    chk("stall_result", b0.out_result, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    chk("stall_in_ready_hold", {31'd0, b0.in_ready}, 32'd0);
    chk("stall_result_hold", b0.out_result, 32'd1);
    b0.out_ready = 1'b1;
    wait fork;
    drain();
    opx(0, 4'd3, 5'd17, 5'd17, 5'd9, 1'b0, 32'h7FFFFFFE, 1'b0);
    drain();

    // Reset mid-stream drops E/X at once and wipes the register file
    b0.out_ready = 1'b0;
    load(0, 5'd20, 32'd1);
    load(0, 5'd21, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, b0.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, b0.in_ready}, 32'd1);
    q0.delete();
    qz.delete();
    for (int i = 0; i < 32; i++) begin rf0[i] = '0; rfz[i] = '0; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    b0.out_ready = 1'b1;
    opx(0, 4'd3, 5'd2, 5'd2, 5'd9, 1'b0, 32'd0, 1'b0);

    // r0 is ordinary here but hardwired to zero on the second instance
    load(0, 5'd0, 32'd7);
    opx(0, 4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd14, 1'b0);
    load(1, 5'd0, 32'd7);
    opx(1, 4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd0, 1'b0);
    load(1, 5'd1, 32'd9);
    opx(1, 4'd0, 5'd1, 5'd0, 5'd2, 1'b1, 32'd9, 1'b0);
    drain();

    chk("q0_empty", q0.size(), 32'd0);
    chk("qz_empty", qz.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
